// File: rtl/lamp_safety_monitor_if.sv
// rtl/lamp_safety_monitor_if.sv - lamp request/drive bundle between controller and safety monitor
interface lamp_safety_monitor_if;
    logic       r1_in;
    logic       y1_in;
    logic       g1_in;
    logic       r2_in;
    logic       y2_in;
    logic       g2_in;
    logic       clear_fault;
    logic       r1;
    logic       y1;
    logic       g1;
    logic       r2;
    logic       y2;
    logic       g2;
    logic       fault;
    logic [2:0] fault_code;

    // Controller side: issues lamp requests and fault acknowledge
    modport master (
        output r1_in, y1_in, g1_in, r2_in, y2_in, g2_in, clear_fault,
        input  r1, y1, g1, r2, y2, g2, fault, fault_code
    );

    // Monitor side: checks requests and drives the lamps
    modport slave (
        input  r1_in, y1_in, g1_in, r2_in, y2_in, g2_in, clear_fault,
        output r1, y1, g1, r2, y2, g2, fault, fault_code
    );
endinterface

// File: rtl/lamp_safety_monitor.sv
// rtl/lamp_safety_monitor.sv - registers controller lamp requests and forces flashing red on unsafe patterns
module lamp_safety_monitor #(
    parameter int CLK_HZ         = 1000000,
    parameter int BLINK_HZ       = 1,
    parameter int STARTUP_CYC    = 1000000,
    parameter int MIN_YELLOW_CYC = 3000000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    lamp_safety_monitor_if.slave  bus
);

    localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
    localparam int SW   = $clog2(STARTUP_CYC) + 1;
    localparam int BW   = $clog2(HALF) + 1;
    localparam int YW   = $clog2(MIN_YELLOW_CYC) + 1;

    localparam logic [SW-1:0] S_LAST = SW'(STARTUP_CYC - 1);
    localparam logic [SW-1:0] S_ONE  = SW'(1);
    localparam logic [BW-1:0] B_LAST = BW'(HALF - 1);
    localparam logic [BW-1:0] B_ONE  = BW'(1);
    localparam logic [YW-1:0] Y_MAX  = YW'(MIN_YELLOW_CYC);
    localparam logic [YW-1:0] Y_ONE  = YW'(1);

    // Lamp vector order is {r1,y1,g1,r2,y2,g2}
    localparam logic [5:0] ALL_RED  = 6'b100_100;
    localparam logic [5:0] ALL_DARK = 6'b000_000;

    localparam logic [2:0] C_NONE     = 3'd0;
    localparam logic [2:0] C_ONEHOT   = 3'd1;
    localparam logic [2:0] C_CONFLICT = 3'd2;
    localparam logic [2:0] C_TRANS    = 3'd3;
    localparam logic [2:0] C_SHORTY   = 3'd4;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_PASS  = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        L_RED = 2'd0,
        L_YEL = 2'd1,
        L_GRN = 2'd2
    } lamp_e;

    state_e        state_q;
    logic [SW-1:0] st_cnt_q;
    logic [BW-1:0] blink_cnt_q;
    logic [YW-1:0] y1_cnt_q;
    logic [YW-1:0] y2_cnt_q;
    lamp_e         prev1_q;
    lamp_e         prev2_q;
    logic [5:0]    lamp_q;
    logic          fault_q;
    logic [2:0]    code_q;

    logic [5:0]    lamp_in;
    lamp_e         dec1;
    lamp_e         dec2;
    logic [2:0]    cause_d;
    logic [YW-1:0] y1_cnt_d;
    logic [YW-1:0] y2_cnt_d;

    // Only meaningful once the one-hot check has passed
    function automatic lamp_e decode(input logic [2:0] ryg);
        case (ryg)
            3'b010:  return L_YEL;
            3'b001:  return L_GRN;
            default: return L_RED;
        endcase
    endfunction

    function automatic logic is_onehot(input logic [2:0] ryg);
        return (ryg == 3'b100) || (ryg == 3'b010) || (ryg == 3'b001);
    endfunction

    // The three forbidden single steps; everything else is a hold or a legal advance
    function automatic logic bad_step(input lamp_e p, input lamp_e n);
        return ((p == L_GRN) && (n == L_RED)) ||
               ((p == L_RED) && (n == L_YEL)) ||
               ((p == L_YEL) && (n == L_GRN));
    endfunction

    // Check the raw requests against the last accepted pattern, highest-priority cause first
    always_comb begin
        lamp_in  = {bus.r1_in, bus.y1_in, bus.g1_in, bus.r2_in, bus.y2_in, bus.g2_in};
        dec1     = decode(lamp_in[5:3]);
        dec2     = decode(lamp_in[2:0]);
        cause_d  = C_NONE;
        if (!is_onehot(lamp_in[5:3]) || !is_onehot(lamp_in[2:0])) begin
            cause_d = C_ONEHOT;
        end else if ((dec1 != L_RED) && (dec2 != L_RED)) begin
            cause_d = C_CONFLICT;
        end else if (bad_step(prev1_q, dec1) || bad_step(prev2_q, dec2)) begin
            cause_d = C_TRANS;
        end else if (((prev1_q == L_YEL) && (dec1 == L_RED) && (y1_cnt_q < Y_MAX)) ||
                     ((prev2_q == L_YEL) && (dec2 == L_RED) && (y2_cnt_q < Y_MAX))) begin
            cause_d = C_SHORTY;
        end
        // Count includes the cycle being accepted so a run of N yellows reads N at the Y->R step
        y1_cnt_d = '0;
        if (dec1 == L_YEL) begin
            y1_cnt_d = (y1_cnt_q == Y_MAX) ? y1_cnt_q : y1_cnt_q + Y_ONE;
        end
        y2_cnt_d = '0;
        if (dec2 == L_YEL) begin
            y2_cnt_d = (y2_cnt_q == Y_MAX) ? y2_cnt_q : y2_cnt_q + Y_ONE;
        end
    end

    // Monitor FSM: startup all-red, pass-through with checking, latched flashing-red fault
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_INIT;
            st_cnt_q    <= '0;
            blink_cnt_q <= '0;
            y1_cnt_q    <= '0;
            y2_cnt_q    <= '0;
            prev1_q     <= L_RED;
            prev2_q     <= L_RED;
            lamp_q      <= ALL_RED;
            fault_q     <= 1'b0;
            code_q      <= C_NONE;
        end else begin
            case (state_q)
                ST_INIT: begin
                    lamp_q  <= ALL_RED;
                    prev1_q <= L_RED;
                    prev2_q <= L_RED;
                    if (st_cnt_q == S_LAST) begin
                        state_q <= ST_PASS;
                    end else begin
                        st_cnt_q <= st_cnt_q + S_ONE;
                    end
                end
                ST_PASS: begin
                    if (cause_d != C_NONE) begin
                        // Offending pattern is never driven: go straight to red/red
                        state_q     <= ST_FAULT;
                        fault_q     <= 1'b1;
                        code_q      <= cause_d;
                        lamp_q      <= ALL_RED;
                        blink_cnt_q <= '0;
                    end else begin
                        lamp_q   <= lamp_in;
                        prev1_q  <= dec1;
                        prev2_q  <= dec2;
                        y1_cnt_q <= y1_cnt_d;
                        y2_cnt_q <= y2_cnt_d;
                    end
                end
                ST_FAULT: begin
                    if (bus.clear_fault) begin
                        state_q  <= ST_INIT;
                        fault_q  <= 1'b0;
                        code_q   <= C_NONE;
                        st_cnt_q <= '0;
                        lamp_q   <= ALL_RED;
                        prev1_q  <= L_RED;
                        prev2_q  <= L_RED;
                        y1_cnt_q <= '0;
                        y2_cnt_q <= '0;
                    end else if (blink_cnt_q == B_LAST) begin
                        blink_cnt_q <= '0;
                        lamp_q      <= lamp_q[5] ? ALL_DARK : ALL_RED;
                    end else begin
                        blink_cnt_q <= blink_cnt_q + B_ONE;
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                end
            endcase
        end
    end

    assign bus.r1         = lamp_q[5];
    assign bus.y1         = lamp_q[4];
    assign bus.g1         = lamp_q[3];
    assign bus.r2         = lamp_q[2];
    assign bus.y2         = lamp_q[1];
    assign bus.g2         = lamp_q[0];
    assign bus.fault      = fault_q;
    assign bus.fault_code = code_q;

endmodule
